// File: rtl/payload_table_decoder_pkg.sv
// Shared definitions for payload_table_decoder.
// Contents: header field positions and widths, error bit indices and the
// decoder FSM state encoding.
package payload_table_decoder_pkg;

  // Header item layout, all within bits [31:0] of the payload item
  localparam int TYPE_MSB   = 31;
  localparam int TYPE_LSB   = 29;
  localparam int TYPE_W     = TYPE_MSB - TYPE_LSB + 1;
  localparam int CNT_MSB    = 28;
  localparam int CNT_LSB    = 16;
  localparam int CNT_W      = CNT_MSB - CNT_LSB + 1;
  localparam int ADDR_MSB   = 15;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_FLD_W = ADDR_MSB - ADDR_LSB + 1;

  // Sticky error bit positions in err_status
  localparam int ERR_TYPE  = 0;
  localparam int ERR_SHORT = 1;
  localparam int ERR_LONG  = 2;
  localparam int ERR_ADDR  = 3;
  localparam int ERR_W     = 4;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/payload_table_decoder.sv
// payload_table_decoder
// Passive monitor on a payload stream. Each packet is one header item
// followed by N table items. The header selects a table, a start address and
// an item count; table items are turned into registered write strobes with
// an incrementing, wrapping address. Length mismatches and bad headers set
// sticky error bits; clean packets pulse pkt_done and bump pkt_count.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_pl_tdata/tlast    monitored payload item and end-of-packet flag
//   s_pl_tvalid/tready  handshake; a beat is tvalid & tready (tready is input)
//   err_clear           pulse clearing err_status (a same-cycle set wins)
//   wr_en/sel/addr/data registered table write, one cycle after the beat
//   pkt_done            one-cycle pulse per clean packet
//   pkt_count           clean packets since reset (wraps)
//   err_status          sticky {bad addr, long, short, unknown type}
module payload_table_decoder
  import payload_table_decoder_pkg::*;
#(
  parameter int ITEM_W     = 32,
  parameter int NUM_TABLES = 4,
  parameter int DEPTH      = 1024,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ITEM_W-1:0]     s_pl_tdata,
  input  logic                  s_pl_tlast,
  input  logic                  s_pl_tvalid,
  input  logic                  s_pl_tready,
  input  logic                  err_clear,
  output logic                  wr_en,
  output logic [NUM_TABLES-1:0] wr_sel,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ITEM_W-1:0]     wr_data,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count,
  output logic [ERR_W-1:0]      err_status
);

  if (ITEM_W < 32) begin : g_bad_item_w
    $error("payload_table_decoder: ITEM_W must be >= 32");
  end
  if (NUM_TABLES < 1 || NUM_TABLES > 7) begin : g_bad_num_tables
    $error("payload_table_decoder: NUM_TABLES must be in 1..7");
  end
  if (ADDR_W < 1 || ADDR_W > ADDR_FLD_W) begin : g_bad_depth
    $error("payload_table_decoder: DEPTH must be in 2..65536");
  end

  localparam logic [TYPE_W-1:0]     NT_L      = TYPE_W'(NUM_TABLES);
  localparam logic [ADDR_FLD_W:0]   DEPTH_L   = (ADDR_FLD_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [NUM_TABLES-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic                    wr_en_q, wr_en_d;
  logic [NUM_TABLES-1:0]   wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [ITEM_W-1:0]       wr_data_q, wr_data_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [15:0]             pkt_count_q, pkt_count_d;
  logic [ERR_W-1:0]        err_q, err_d;

  logic                    beat;
  logic [TYPE_W-1:0]       hdr_type;
  logic [CNT_W-1:0]        hdr_cnt;
  logic [ADDR_FLD_W-1:0]   hdr_start;
  logic                    hdr_start_bad;
  logic [NUM_TABLES-1:0]   hdr_sel;
  logic [ERR_W-1:0]        err_set;
  logic                    done_evt;

  assign beat          = s_pl_tvalid & s_pl_tready;
  assign hdr_type      = s_pl_tdata[TYPE_MSB:TYPE_LSB];
  assign hdr_cnt       = s_pl_tdata[CNT_MSB:CNT_LSB];
  assign hdr_start     = s_pl_tdata[ADDR_MSB:ADDR_LSB];
  assign hdr_start_bad = {1'b0, hdr_start} >= DEPTH_L;

  // Type t (1-based) selects table t-1
  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < NUM_TABLES; i++) begin
      hdr_sel[i] = (hdr_type == TYPE_W'(i + 1));
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_set    = '0;
    done_evt   = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        if (beat) begin
          if (hdr_type == '0) begin
            // Null packet: skipped silently
            state_d = s_pl_tlast ? ST_HDR : ST_DRAIN;
          end else if (hdr_type > NT_L) begin
            err_set[ERR_TYPE] = 1'b1;
            state_d = s_pl_tlast ? ST_HDR : ST_DRAIN;
          end else if (hdr_start_bad) begin
            err_set[ERR_ADDR] = 1'b1;
            state_d = s_pl_tlast ? ST_HDR : ST_DRAIN;
          end else if (hdr_cnt == '0) begin
            if (s_pl_tlast) begin
              done_evt = 1'b1;
            end else begin
              err_set[ERR_LONG] = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_pl_tlast) begin
            err_set[ERR_SHORT] = 1'b1;
          end else begin
            sel_d   = hdr_sel;
            addr_d  = hdr_start[ADDR_W-1:0];
            rem_d   = hdr_cnt;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = sel_q;
          wr_addr_d = addr_q;
          wr_data_d = s_pl_tdata;
          addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            if (s_pl_tlast) begin
              done_evt = 1'b1;
              state_d  = ST_HDR;
            end else begin
              err_set[ERR_LONG] = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_pl_tlast) begin
            // Truncated packet: writes already issued are kept
            err_set[ERR_SHORT] = 1'b1;
            state_d = ST_HDR;
          end
        end
      end

      ST_DRAIN: begin
        if (beat && s_pl_tlast) begin
          state_d = ST_HDR;
        end
      end

      default: state_d = ST_HDR;
    endcase

    pkt_done_d  = done_evt;
    pkt_count_d = done_evt ? pkt_count_q + 16'd1 : pkt_count_q;
    // Set has priority over a coincident clear
    err_d       = (err_clear ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      sel_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_count  = pkt_count_q;
  assign err_status = err_q;

endmodule
